data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words stored.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the word-address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-003 The block SHALL have parameter LATENCY, default 2, giving busy cycles per access; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_memory_en, input, 1 bit: access request, driven by the pipeline controller's memory enable.
REQ-007 The block SHALL have port i_we, input, 1 bit: 1 for a write, 0 for a read.
REQ-008 The block SHALL have port i_addr, input, ADDR_W bits: word address.
REQ-009 The block SHALL have port i_wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port i_wstrb, input, 4 bits: byte-lane write enables.
REQ-011 The block SHALL have port o_memory_ready, output, 1 bit: memory idle or access complete, feeding the controller's memory-ready input.
REQ-012 The block SHALL have port o_rdata, output, 32 bits: read data of the last completed read.
REQ-013 The block SHALL have port o_err, output, 1 bit: the last completed access faulted.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 A request SHALL be accepted only when i_memory_en=1 in IDLE or DONE; i_we, i_addr, i_wdata and i_wstrb SHALL be latched on that edge.
REQ-016 On accept, the FSM SHALL go to BUSY with a 4-bit counter loaded with LATENCY-1.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at counter=0 the FSM SHALL go to DONE.
REQ-018 In DONE, a new accepted request SHALL go to BUSY, otherwise DONE SHALL persist for exactly one cycle before returning to IDLE.
REQ-019 o_memory_ready SHALL be registered: 1 in IDLE and DONE, 0 in BUSY; it SHALL drop on the cycle after accept and rise on the cycle DONE is entered, giving a low window of exactly LATENCY cycles.
REQ-020 i_memory_en asserted in BUSY SHALL be ignored: no latch, no state change, no memory side effect.
REQ-021 A read SHALL update o_rdata on entry to DONE; o_rdata SHALL hold until the next completed read, and writes SHALL NOT change it.
REQ-022 A write SHALL commit on entry to DONE, only for byte lanes with i_wstrb[n]=1; i_wstrb=0 SHALL complete normally with no change to memory.
REQ-023 A read-after-write to the same address SHALL return the newly written bytes.
REQ-024 o_err SHALL be updated on every DONE entry and held otherwise.

Reset
REQ-025 While rst=1, the FSM SHALL be IDLE, the counter 0, o_memory_ready=0, o_rdata=0 and o_err=0; o_memory_ready SHALL be 1 on the first cycle after rst falls.
REQ-026 rst asserted in BUSY SHALL abort the access with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-027 With macro DATA_MEM_RESPONDER_RANGE_CHECK_EN defined, an access with i_addr >= DEPTH SHALL set o_err=1 at DONE, SHALL suppress any write, and a read SHALL return o_rdata=0.
REQ-028 Without DATA_MEM_RESPONDER_RANGE_CHECK_EN, o_err SHALL be tied 0 and the address SHALL wrap modulo DEPTH.

Structure
REQ-029 Package gpu_mem_pkg SHALL hold the state enum mem_resp_state_t (IDLE, BUSY, DONE), the word-width constant 32 and the default LATENCY.
REQ-030 Sub-module mem_sram_bank SHALL hold the DEPTH x 32 array with per-byte write enables and a synchronous read; the FSM, counter and error logic SHALL stay in the top module.

Verification
REQ-031 Scenario: after reset with LATENCY=2, write addr 0x10, data 0xDEADBEEF, wstrb 0xF -> o_memory_ready low for exactly 2 cycles, then high, with o_err=0.
REQ-032 Scenario: read addr 0x10 after the write -> o_rdata=0xDEADBEEF on DONE entry; then write 0x000000AA with wstrb 0x1 and read again -> o_rdata=0xDEADBEAA.
REQ-033 Scenario: i_memory_en pulsed during BUSY with a write to addr 0x20 -> ignored; a subsequent read of 0x20 returns its prior contents.
REQ-034 Scenario: with the range-check macro and DEPTH=200, read addr 0xF0 -> o_err=1 and o_rdata=0; a write to 0xF0 leaves the wrapped location 0x28 unchanged.
REQ-035 Scenario: rst pulsed on the first BUSY cycle of a write to 0x30 -> o_memory_ready=0 during reset, 1 after reset, and addr 0x30 unchanged.
REQ-036 Scenario: back-to-back requests issued in DONE with LATENCY=1 -> each accepted, with o_memory_ready low for exactly 1 cycle per access.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the data-memory responder and its SRAM bank.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_resp_state_t;

  localparam int MEM_WORD_W          = 32;
  localparam int MEM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_sram_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module mem_sram_bank
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the responder's state is.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem[addr][7:0]   <= wdata[7:0];
    if (we && be[1]) mem[addr][15:8]  <= wdata[15:8];
    if (we && be[2]) mem[addr][23:16] <= wdata[23:16];
    if (we && be[3]) mem[addr][31:24] <= wdata[31:24];
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: ready low for LATENCY cycles per access, ignores requests while busy.
// DATA_MEM_RESPONDER_RANGE_CHECK_EN enables out-of-range faulting; otherwise addresses wrap modulo DEPTH.
module data_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = MEM_DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_memory_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic                  o_memory_ready,
  output logic [MEM_WORD_W-1:0] o_rdata,
  output logic                  o_err
);

  mem_resp_state_t       state_q, state_nxt;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [MEM_WORD_W-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic                  accept;
  logic                  done_enter;
  logic                  oob;
  logic                  bank_we;
  logic [ADDR_W-1:0]     bank_addr;
  logic [MEM_WORD_W-1:0] bank_rdata;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
`ifdef DATA_MEM_RESPONDER_RANGE_CHECK_EN
    return a;
`else
    return ADDR_W'(32'(a) % 32'(DEPTH));
`endif
  endfunction

  assign accept     = i_memory_en && (state_q != BUSY);
  assign done_enter = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DATA_MEM_RESPONDER_RANGE_CHECK_EN
  assign oob = (32'(addr_q) >= 32'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    state_nxt = accept ? BUSY : IDLE;
      BUSY:    state_nxt = (cnt_q == 4'd0) ? DONE : BUSY;
      DONE:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The read is launched on the accept edge so the bank output is settled
  // by DONE entry; the single port is only needed for the write at DONE entry.
  assign bank_we   = done_enter && we_q && !oob && !rst;
  assign bank_addr = done_enter ? map_addr(addr_q) : map_addr(i_addr);

  mem_sram_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (wstrb_q),
    .re    (accept),
    .addr  (bank_addr),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= 4'd0;
      o_memory_ready <= 1'b0;
      o_rdata        <= '0;
    end else begin
      state_q        <= state_nxt;
      o_memory_ready <= (state_nxt != BUSY);
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        we_q    <= i_we;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        wstrb_q <= i_wstrb;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (done_enter && !we_q) begin
        o_rdata <= oob ? '0 : bank_rdata;
      end
    end
  end

`ifdef DATA_MEM_RESPONDER_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)             err_q <= 1'b0;
    else if (done_enter) err_q <= oob;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
